reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32x32 register file between NUM_REQ writeback requesters.
//  Example requesters: ALU result, load return, debug/host write.
//  Round-robin grant with per-requester valid/ready handshake; one registered output stage drives
//  write_enable/write_reg/write_data of the register file. Also tracks contention for perf/debug.
// PARAMETERS
//  NUM_REQ        3   number of writeback requesters (2..8)
//  ZERO_PROTECT   1   1: writes to reg 0 are accepted but never reach the register file
//  CNT_W          16  width of the saturating contention counter
// PORTS
//  clk            in   1              rising-edge clock
//  reset_n        in   1              asynchronous active-low reset
//  req_valid      in   NUM_REQ        requester i has a write pending
//  req_addr       in   NUM_REQ*5      flat; requester i at [i*5 +: 5]
//  req_data       in   NUM_REQ*32     flat; requester i at [i*32 +: 32]
//  req_ready      out  NUM_REQ        one-hot or zero; requester i accepted this cycle
//  stall          in   1              1: grant nobody this cycle
//  write_enable   out  1              to register file write_enable (registered)
//  write_reg      out  5              to register file write_reg (registered)
//  write_data     out  32             to register file write_data (registered)
//  grant_id       out  clog2(NUM_REQ) index of requester that produced current output
//  pending_mask   out  32             bit r = 1 while write to reg r sits in output stage
//  contention_cnt out  CNT_W          cycles with >=2 req_valid and stall=0, saturating
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - write_enable=0, write_reg=0, write_data=0, grant_id=0, pending_mask=0, contention_cnt=0
//   - rr pointer last=NUM_REQ-1, so requester 0 has top priority first
//  Grant (combinational):
//   - if stall=0, the first valid requester searching last+1, last+2, ... (mod NUM_REQ) wins
//   - req_ready is high for the winner only; all zero if stall=1 or no valid
//   - accept = req_valid[i] & req_ready[i]; requester must hold addr/data stable until accepted
//  Pointer: on accept, last<=winner; unchanged otherwise.
//  Output stage, every edge:
//   - on accept: write_reg<=addr, write_data<=data, grant_id<=winner,
//     write_enable<=~(ZERO_PROTECT & addr==0)
//   - no accept: write_enable<=0; write_reg/write_data/grant_id hold
//  Latency: accept in cycle N -> write_enable high in cycle N+1 -> reg file updated at end of N+1.
//  Throughput: one write per cycle, no bubbles when requesters stay valid.
//  pending_mask: one-hot of write_reg when write_enable=1, else 0 (registered with the stage).
//  contention_cnt: +1 per cycle with popcount(req_valid)>=2 and stall=0; holds at all-ones.
//  Boundaries:
//   - single valid requester always wins regardless of pointer
//   - pointer wraps NUM_REQ-1 -> 0
//   - stall asserted while valid: no ready, write_enable drops next cycle, pointer frozen
//   - reset mid-operation: output stage dropped (write lost); requesters re-present after reset
//   - ZERO_PROTECT=0: reg 0 written like any other
// STRUCTURE
//  Shared package (cpu_pkg):
//   - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32
//   - wb_req_t {addr, data}, used by all writeback sources
//  Sub-module rr_arbiter:
//   - params N; ports clk, reset_n, req, en, gnt (one-hot), gnt_idx
//   - owns the pointer; reused later for the memory port
//  Top: contains mux, output register, pending_mask, contention counter.
// TESTING
//  1. reset, req_valid=001, addr=5, data=0xDEADBEEF
//     -> ready=001 same cycle; next cycle write_enable=1, write_reg=5, pending_mask=0x20
//  2. all 3 valid for 6 cycles from reset
//     -> grant order 0,1,2,0,1,2; write_enable high 6 consecutive cycles; contention_cnt=6
//  3. req_valid=011 with stall=1 for 3 cycles, then stall=0
//     -> no ready during stall; first grant goes to 0; counter unchanged during stall
//  4. ZERO_PROTECT=1, write addr=0 data=0x1234
//     -> ready=1, write_enable stays 0, reg 0 still 0 after readback via reg_file
//  5. reset_n low the cycle after an accept
//     -> write_enable=0 and pending_mask=0 immediately; register unchanged; pointer back to NUM_REQ-1
//  6. force contention for 2^CNT_W+5 cycles -> contention_cnt saturates at all-ones

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: register file geometry and the
// writeback request bundle used by every writeback source.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // Index width for an N-way selector, never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last
// winner; the pointer moves only when a grant is issued.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] r_last;
    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_found;

    // Search indices above the pointer first, then wrap to 0..last.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !w_found && req[i] && (i > int'(r_last))) begin
                w_found  = 1'b1;
                w_gnt[i] = 1'b1;
                w_idx    = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && !w_found && req[i] && (i <= int'(r_last))) begin
                w_found  = 1'b1;
                w_gnt[i] = 1'b1;
                w_idx    = IW'(i);
            end
        end
    end

    // Pointer remembers the most recent winner; reset favours index 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= IW'(N - 1);
        end else if (w_found) begin
            r_last <= w_idx;
        end
    end

    assign gnt     = w_gnt;
    assign gnt_idx = w_idx;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file write port between NUM_REQ writeback
// sources through a round-robin grant and one output register.
module reg_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter bit ZERO_PROTECT = 1'b1,
    parameter int CNT_W        = 16,
    localparam int GW = idx_w(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         stall,
    output logic                         write_enable,
    output logic [REG_ADDR_W-1:0]        write_reg,
    output logic [DATA_W-1:0]            write_data,
    output logic [GW-1:0]                grant_id,
    output logic [NUM_REGS-1:0]          pending_mask,
    output logic [CNT_W-1:0]             contention_cnt
);

    logic [NUM_REQ-1:0]    w_gnt;
    logic [GW-1:0]         w_gnt_idx;
    logic                  w_accept;
    logic                  w_we_next;
    logic                  w_contend;
    wb_req_t               w_sel;

    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_reg;
    logic [DATA_W-1:0]     r_data;
    logic [GW-1:0]         r_gid;
    logic [NUM_REGS-1:0]   r_pending;
    logic [CNT_W-1:0]      r_cnt;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .en      (~stall),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |(req_valid & w_gnt);
    assign w_contend = ~stall && ($countones(req_valid) >= 2);

    // Select the winner's address/data (grant is one-hot or zero).
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                w_sel.data = req_data[i*DATA_W +: DATA_W];
            end
        end
        w_we_next = ~(ZERO_PROTECT && (w_sel.addr == '0));
    end

    // Output stage: capture accepted write, otherwise drop enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we      <= 1'b0;
            r_reg     <= '0;
            r_data    <= '0;
            r_gid     <= '0;
            r_pending <= '0;
        end else if (w_accept) begin
            r_we      <= w_we_next;
            r_reg     <= w_sel.addr;
            r_data    <= w_sel.data;
            r_gid     <= w_gnt_idx;
            r_pending <= w_we_next
                ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << w_sel.addr)
                : '0;
        end else begin
            r_we      <= 1'b0;
            r_pending <= '0;
        end
    end

    // Saturating count of cycles where two or more sources compete.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_contend && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign write_enable   = r_we;
    assign write_reg      = r_reg;
    assign write_data     = r_data;
    assign grant_id       = r_gid;
    assign pending_mask   = r_pending;
    assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomised and directed bench for reg_wb_arbiter, checked against
// a round-robin reference model and a shadow register file.
module tb_reg_wb_arbiter;

    localparam int N  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_valid;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          stall;
    logic          write_enable;
    logic [4:0]    write_reg;
    logic [31:0]   write_data;
    logic [1:0]    grant_id;
    logic [31:0]   pending_mask;
    logic [CW-1:0] contention_cnt;

    reg_wb_arbiter #(
        .NUM_REQ      (N),
        .ZERO_PROTECT (1'b1),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .stall          (stall),
        .write_enable   (write_enable),
        .write_reg      (write_reg),
        .write_data     (write_data),
        .grant_id       (grant_id),
        .pending_mask   (pending_mask),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [4:0]  a_q [N];
    logic [31:0] d_q [N];
    logic [31:0] rf [32];

    int          m_last;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_gid;
    int          m_cnt;
    logic [N-1:0] g_ready;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_we = 0; m_reg = 0; m_data = 0; m_gid = 0; m_cnt = 0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic st);
        if (st) return -1;
        for (int k = 1; k <= N; k++)
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    task automatic chk_outputs();
        logic [31:0] pm;
        pm = m_we ? (32'd1 << m_reg) : 32'd0;
        chk("write_enable", 32'(write_enable), 32'(m_we));
        chk("write_reg", 32'(write_reg), 32'(m_reg));
        chk("write_data", write_data, m_data);
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("pending_mask", pending_mask, pm);
        chk("contention_cnt", 32'(contention_cnt), 32'(m_cnt));
    endtask

    // One clock: drive, check grant, advance model, check registers.
    task automatic cycle(input logic [N-1:0] v, input logic st);
        int w;
        logic pw; logic [4:0] pr; logic [31:0] pd;
        @(negedge clk);
        req_valid = v;
        stall = st;
        for (int i = 0; i < N; i++) begin
            req_addr[i*5 +: 5]   = a_q[i];
            req_data[i*32 +: 32] = d_q[i];
        end
        #1;
        w = pick(v, st);
        g_ready = req_ready;
        chk("req_ready", 32'(req_ready),
            (w < 0) ? 32'd0 : (32'd1 << w));
        pw = write_enable; pr = write_reg; pd = write_data;
        @(posedge clk);
        if (pw) rf[pr] = pd;
        if (!st && ($countones(v) >= 2) && (m_cnt < (1 << CW) - 1))
            m_cnt++;
        if (w >= 0) begin
            m_last = w;
            m_gid  = w;
            m_reg  = a_q[w];
            m_data = d_q[w];
            m_we   = (a_q[w] != 0);
        end else begin
            m_we = 0;
        end
        #1;
        chk_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        req_valid = '0;
        stall = 0;
        model_reset();
        #1;
        chk_outputs();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        logic [N-1:0] v;
        logic [31:0] snap;
        reset_n = 0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        stall = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        for (int i = 0; i < N; i++) begin
            a_q[i] = 5'(i + 1);
            d_q[i] = 32'h100 + 32'(i);
        end
        model_reset();
        do_reset();

        // single requester, first accept and latency
        a_q[0] = 5; d_q[0] = 32'hDEADBEEF;
        cycle(3'b001, 0);
        chk("t1_ready", 32'(g_ready), 32'h1);
        chk("t1_we", 32'(write_enable), 32'h1);
        chk("t1_reg", 32'(write_reg), 32'd5);
        chk("t1_mask", pending_mask, 32'h20);
        cycle(3'b000, 0);
        chk("t1_rf5", rf[5], 32'hDEADBEEF);

        // full contention, round-robin order with wrap
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(3'b111, 0);
            chk("t2_gid", 32'(grant_id), 32'(k % 3));
            chk("t2_we", 32'(write_enable), 32'h1);
        end
        chk("t2_cnt", 32'(contention_cnt), 32'd6);

        // stall freezes grant, pointer and counter
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(3'b011, 1);
            chk("t3_ready", 32'(g_ready), 32'h0);
            chk("t3_cnt", 32'(contention_cnt), 32'd0);
        end
        cycle(3'b011, 0);
        chk("t3_first", 32'(g_ready), 32'h1);

        // write to reg 0 is accepted but dropped
        do_reset();
        a_q[0] = 0; d_q[0] = 32'h1234;
        cycle(3'b001, 0);
        chk("t4_ready", 32'(g_ready), 32'h1);
        chk("t4_we", 32'(write_enable), 32'h0);
        cycle(3'b000, 0);
        chk("t4_rf0", rf[0], 32'h0);

        // reset right after accept loses the write, rewinds pointer
        do_reset();
        a_q[1] = 7; d_q[1] = 32'hCAFE0007;
        snap = rf[7];
        cycle(3'b010, 0);
        chk("t5_we_pre", 32'(write_enable), 32'h1);
        do_reset();
        chk("t5_we", 32'(write_enable), 32'h0);
        chk("t5_mask", pending_mask, 32'h0);
        for (int i = 0; i < N; i++) a_q[i] = 5'(10 + i);
        cycle(3'b111, 0);
        chk("t5_ptr", 32'(g_ready), 32'h1);
        chk("t5_rf7", rf[7], snap);

        // counter saturation
        do_reset();
        for (int k = 0; k < (1 << CW) + 5; k++) cycle(3'b110, 0);
        chk("t6_sat", 32'(contention_cnt), 32'hF);

        // random traffic: sources hold until accepted
        do_reset();
        v = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom_range(0, 2) != 0)) begin
                    v[i]   = 1'b1;
                    a_q[i] = 5'($urandom_range(0, 31));
                    d_q[i] = $urandom;
                end
            end
            cycle(v, ($urandom_range(0, 4) == 0));
            v = v & ~g_ready;
            if (k == 200) begin
                do_reset();
                v = '0;
            end
        end
        cycle('0, 0);
        for (int r = 0; r < 32; r++)
            if (r != 0 && rf[r] != 32'h0) chk("rf_nz", 32'(rf[r] != 0), 32'h1);
        chk("rf0_final", rf[0], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
